// File: rtl/vending_pkg.sv
// ============================================================================
// Package     : vending_pkg
// Description : Shared coin encoding, coin values (in nickels) and the
//               change-dispenser state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vending_pkg;

  // Coin encoding shared by the ejector interface and the refill port
  typedef enum logic [1:0] {
    COIN_NONE    = 2'b00,
    COIN_NICKEL  = 2'b01,
    COIN_DIME    = 2'b10,
    COIN_QUARTER = 2'b11
  } coin_t;

  // Coin values expressed in nickels
  localparam logic [2:0] C_VAL_NICKEL  = 3'd1;
  localparam logic [2:0] C_VAL_DIME    = 3'd2;
  localparam logic [2:0] C_VAL_QUARTER = 3'd5;

  // Dispenser sequencing states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_EJECT  = 2'd2,
    ST_FINISH = 2'd3
  } disp_state_t;

  // Value of a coin in nickels; NONE is worth nothing
  function automatic logic [2:0] coin_value(input coin_t c);
    case (c)
      COIN_NICKEL:  coin_value = C_VAL_NICKEL;
      COIN_DIME:    coin_value = C_VAL_DIME;
      COIN_QUARTER: coin_value = C_VAL_QUARTER;
      default:      coin_value = 3'd0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/change_dispenser_coin_stock.sv
// ============================================================================
// Module      : coin_stock
// Description : Saturating up/down stock counter for one coin type.
//               Simultaneous inc and dec cancel out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module coin_stock #(
  parameter int WIDTH = 4,
  parameter int INIT  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [WIDTH-1:0] o_count,
  output logic             o_nonzero
);

  localparam logic [WIDTH-1:0] C_MAX  = '1;
  localparam logic [WIDTH-1:0] C_INIT = WIDTH'(INIT);

  logic [WIDTH-1:0] r_count;

  // Count up on refill, down on ejection, clamped at both ends
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= C_INIT;
    end else if (i_inc && !i_dec) begin
      if (r_count != C_MAX) r_count <= r_count + 1'b1;
    end else if (i_dec && !i_inc) begin
      if (r_count != '0) r_count <= r_count - 1'b1;
    end
  end

  assign o_count   = r_count;
  assign o_nonzero = (r_count != '0);

endmodule

`default_nettype wire

// File: rtl/change_dispenser.sv
// ============================================================================
// Module      : change_dispenser
// Description : Pays change greedily (quarter, dime, nickel) one coin at a
//               time over a valid/ready ejector handshake, tracking coin
//               stock and flagging unpayable change.
//               Optional macro CHANGE_TIMEOUT_EN adds an ejector timeout that
//               raises fault and abandons the transaction.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module change_dispenser
  import vending_pkg::*;
#(
  parameter int STOCK_WIDTH   = 4,
  parameter int STOCK_INIT    = 3,
  parameter int EJECT_TIMEOUT = 16
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic                   start,
  input  logic [2:0]             change,
  output logic                   eject_valid,
  output logic [1:0]             eject_coin,
  input  logic                   eject_ready,
  input  logic                   refill,
  input  logic [1:0]             refill_coin,
  output logic                   busy,
  output logic                   done,
  output logic                   short,
  output logic                   fault,
  output logic [2:0]             remaining,
  output logic [STOCK_WIDTH-1:0] stock_nickel,
  output logic [STOCK_WIDTH-1:0] stock_dime,
  output logic [STOCK_WIDTH-1:0] stock_quarter
);

  disp_state_t r_state, w_state_nxt;
  coin_t       r_coin, w_coin_nxt, w_pick;
  logic [2:0]  r_remaining, w_remaining_nxt;
  logic        r_short, w_short_nxt;
  logic        w_xfer;
  logic        w_n_nz, w_d_nz, w_q_nz;

  assign w_xfer = (r_state == ST_EJECT) && eject_ready;

  coin_stock #(.WIDTH(STOCK_WIDTH), .INIT(STOCK_INIT)) u_stock_nickel (
    .clk(clock), .rst(clear),
    .i_inc(refill && (refill_coin == COIN_NICKEL)),
    .i_dec(w_xfer && (r_coin == COIN_NICKEL)),
    .o_count(stock_nickel), .o_nonzero(w_n_nz)
  );

  coin_stock #(.WIDTH(STOCK_WIDTH), .INIT(STOCK_INIT)) u_stock_dime (
    .clk(clock), .rst(clear),
    .i_inc(refill && (refill_coin == COIN_DIME)),
    .i_dec(w_xfer && (r_coin == COIN_DIME)),
    .o_count(stock_dime), .o_nonzero(w_d_nz)
  );

  coin_stock #(.WIDTH(STOCK_WIDTH), .INIT(STOCK_INIT)) u_stock_quarter (
    .clk(clock), .rst(clear),
    .i_inc(refill && (refill_coin == COIN_QUARTER)),
    .i_dec(w_xfer && (r_coin == COIN_QUARTER)),
    .o_count(stock_quarter), .o_nonzero(w_q_nz)
  );

`ifdef CHANGE_TIMEOUT_EN
  localparam int C_TMO_W = $clog2(EJECT_TIMEOUT + 1);
  logic [C_TMO_W-1:0] r_tmo;
  logic               r_fault, w_fault_nxt;
  logic               w_tmo_hit;

  assign w_tmo_hit = (r_state == ST_EJECT) && !eject_ready &&
                     (r_tmo == C_TMO_W'(EJECT_TIMEOUT - 1));

  // Count stalled EJECT cycles; restarts whenever the stall ends
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_tmo <= '0;
    end else if ((r_state == ST_EJECT) && !eject_ready) begin
      r_tmo <= r_tmo + 1'b1;
    end else begin
      r_tmo <= '0;
    end
  end

  // Fault flag register
  always_ff @(posedge clock or posedge clear) begin
    if (clear) r_fault <= 1'b0;
    else       r_fault <= w_fault_nxt;
  end

  assign fault = r_fault;
`else
  assign fault = 1'b0;
`endif

  // Greedy coin choice from the current remaining amount and stock
  always_comb begin
    w_pick = COIN_NONE;
    if ((r_remaining >= C_VAL_QUARTER) && w_q_nz)   w_pick = COIN_QUARTER;
    else if ((r_remaining >= C_VAL_DIME) && w_d_nz) w_pick = COIN_DIME;
    else if ((r_remaining >= C_VAL_NICKEL) && w_n_nz) w_pick = COIN_NICKEL;
  end

  // State and datapath registers
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state     <= ST_IDLE;
      r_coin      <= COIN_NONE;
      r_remaining <= 3'd0;
      r_short     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_coin      <= w_coin_nxt;
      r_remaining <= w_remaining_nxt;
      r_short     <= w_short_nxt;
    end
  end

  // Next-state and datapath update
  always_comb begin
    w_state_nxt     = r_state;
    w_coin_nxt      = r_coin;
    w_remaining_nxt = r_remaining;
    w_short_nxt     = r_short;
`ifdef CHANGE_TIMEOUT_EN
    w_fault_nxt     = r_fault;
`endif
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_remaining_nxt = change;
          w_short_nxt     = 1'b0;
`ifdef CHANGE_TIMEOUT_EN
          w_fault_nxt     = 1'b0;
`endif
          w_state_nxt     = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (w_pick != COIN_NONE) begin
          w_coin_nxt  = w_pick;
          w_state_nxt = ST_EJECT;
        end else begin
          if (r_remaining != 3'd0) w_short_nxt = 1'b1;
          w_state_nxt = ST_FINISH;
        end
      end
      ST_EJECT: begin
        if (eject_ready) begin
          w_remaining_nxt = r_remaining - coin_value(r_coin);
          w_coin_nxt      = COIN_NONE;
          w_state_nxt     = ST_SELECT;
        end
`ifdef CHANGE_TIMEOUT_EN
        else if (w_tmo_hit) begin
          w_fault_nxt = 1'b1;
          w_coin_nxt  = COIN_NONE;
          w_state_nxt = ST_FINISH;
        end
`endif
      end
      ST_FINISH: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign eject_valid = (r_state == ST_EJECT);
  assign eject_coin  = r_coin;
  assign busy        = (r_state != ST_IDLE);
  assign done        = (r_state == ST_FINISH);
  assign short       = r_short;
  assign remaining   = r_remaining;

endmodule

`default_nettype wire

// File: tb/tb_change_dispenser.sv
// ============================================================================
// Module      : tb_change_dispenser
// Description : Self-checking bench for change_dispenser against a greedy
//               change-making reference model with per-coin stock tracking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_change_dispenser;

  logic       clock = 1'b0;
  logic       clear = 1'b1;
  logic       start = 1'b0;
  logic [2:0] change = 3'd0;
  logic       eject_ready = 1'b0;
  logic       refill = 1'b0;
  logic [1:0] refill_coin = 2'd0;
  logic       eject_valid, busy, done, short, fault;
  logic [1:0] eject_coin;
  logic [2:0] remaining;
  logic [3:0] stock_nickel, stock_dime, stock_quarter;

  int n_cmp = 0;
  int n_fail = 0;
  int ms[4];  // model stock, index = coin code (1 nickel, 2 dime, 3 quarter)

  always #5 clock = ~clock;

  change_dispenser dut (
    .clock(clock), .clear(clear), .start(start), .change(change),
    .eject_valid(eject_valid), .eject_coin(eject_coin), .eject_ready(eject_ready),
    .refill(refill), .refill_coin(refill_coin), .busy(busy), .done(done),
    .short(short), .fault(fault), .remaining(remaining),
    .stock_nickel(stock_nickel), .stock_dime(stock_dime), .stock_quarter(stock_quarter)
  );

  function automatic int cval(input int c);
    if (c == 3) return 5;
    if (c == 2) return 2;
    if (c == 1) return 1;
    return 0;
  endfunction

  // Greedy change-making rule: biggest coin that fits and is in stock
  function automatic int pick(input int rem);
    if (rem >= 5 && ms[3] > 0) return 3;
    if (rem >= 2 && ms[2] > 0) return 2;
    if (rem >= 1 && ms[1] > 0) return 1;
    return 0;
  endfunction

  task automatic check_stocks(input string tag);
    n_cmp++;
    if ({stock_nickel, stock_dime, stock_quarter} !== {4'(ms[1]), 4'(ms[2]), 4'(ms[3])}) begin
      n_fail++;
      $display("FAIL %s stocks: got n=%0d d=%0d q=%0d want n=%0d d=%0d q=%0d",
               tag, stock_nickel, stock_dime, stock_quarter, ms[1], ms[2], ms[3]);
    end
  endtask

  task automatic reset_dut();
    clear = 1'b1; start = 1'b0; eject_ready = 1'b0; refill = 1'b0;
    @(negedge clock); @(negedge clock);
    clear = 1'b0;
    ms[1] = 3; ms[2] = 3; ms[3] = 3;
  endtask

  // One full transaction with bench-predicted coin sequence and timing
  task automatic run_txn(input int chg, input int max_dly, input bit refill_same,
                         input bit busy_start, input string tag);
    int rem, c, d;
    bit first;
    rem = chg; first = 1'b1;
    @(negedge clock); start = 1'b1; change = 3'(chg);
    @(negedge clock); start = 1'b0;
    n_cmp++;
    if ({busy, eject_valid, done, short, remaining} !== {1'b1, 1'b0, 1'b0, 1'b0, 3'(chg)}) begin
      n_fail++;
      $display("FAIL %s select: got busy=%b valid=%b done=%b short=%b rem=%0d want 1 0 0 0 %0d",
               tag, busy, eject_valid, done, short, remaining, chg);
    end
    for (int k = 0; k < 10; k++) begin
      c = pick(rem);
      @(negedge clock);
      if (c == 0) begin
        n_cmp++;
        if ({done, eject_valid, short, fault, remaining} !== {1'b1, 1'b0, (rem != 0), 1'b0, 3'(rem)}) begin
          n_fail++;
          $display("FAIL %s finish: got done=%b valid=%b short=%b fault=%b rem=%0d want 1 0 %b 0 %0d",
                   tag, done, eject_valid, short, fault, remaining, (rem != 0), rem);
        end
        break;
      end
      n_cmp++;
      if ({eject_valid, eject_coin} !== {1'b1, 2'(c)}) begin
        n_fail++;
        $display("FAIL %s eject: got valid=%b coin=%0d want 1 %0d", tag, eject_valid, eject_coin, c);
      end
      d = $urandom_range(0, max_dly);
      if (busy_start && first && d == 0) d = 1;
      for (int j = 0; j < d; j++) begin
        if (busy_start && first && j == 0) begin start = 1'b1; change = 3'd7; end
        @(negedge clock);
        start = 1'b0;
        n_cmp++;
        if ({eject_valid, eject_coin, remaining} !== {1'b1, 2'(c), 3'(rem)}) begin
          n_fail++;
          $display("FAIL %s stall: got valid=%b coin=%0d rem=%0d want 1 %0d %0d",
                   tag, eject_valid, eject_coin, remaining, c, rem);
        end
      end
      eject_ready = 1'b1;
      if (refill_same) begin refill = 1'b1; refill_coin = 2'(c); end
      @(negedge clock);
      eject_ready = 1'b0; refill = 1'b0;
      rem = rem - cval(c);
      if (!refill_same) ms[c] = ms[c] - 1;
      first = 1'b0;
      n_cmp++;
      if ({eject_valid, eject_coin, remaining} !== {1'b0, 2'b00, 3'(rem)}) begin
        n_fail++;
        $display("FAIL %s xfer: got valid=%b coin=%0d rem=%0d want 0 0 %0d",
                 tag, eject_valid, eject_coin, remaining, rem);
      end
      check_stocks({tag, "_xfer"});
    end
    @(negedge clock);
    n_cmp++;
    if ({done, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL %s idle: got done=%b busy=%b want 0 0", tag, done, busy);
    end
  endtask

  task automatic do_refill(input int c, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock); refill = 1'b1; refill_coin = 2'(c);
      if (c != 0 && ms[c] < 15) ms[c] = ms[c] + 1;
    end
    @(negedge clock); refill = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    n_cmp++;
    if ({eject_valid, eject_coin, busy, done, short, fault, remaining} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset outs: got valid=%b coin=%0d busy=%b done=%b short=%b fault=%b rem=%0d want all 0",
               eject_valid, eject_coin, busy, done, short, fault, remaining);
    end
    check_stocks("reset");
  endtask

  task automatic test_greedy();
    reset_dut(); run_txn(4, 0, 1'b0, 1'b0, "chg4");
    reset_dut(); run_txn(7, 1, 1'b0, 1'b0, "chg7");
    reset_dut(); run_txn(0, 0, 1'b0, 1'b0, "chg0");
  endtask

  task automatic test_short();
    reset_dut();
    for (int i = 0; i < 3; i++) run_txn(2, 0, 1'b0, 1'b0, "drain_dime");
    run_txn(4, 0, 1'b0, 1'b0, "nickels");
    run_txn(1, 0, 1'b0, 1'b0, "short1");
    run_txn(0, 0, 1'b0, 1'b0, "short_clr");
  endtask

  task automatic test_stall();
    reset_dut();
    run_txn(2, 5, 1'b0, 1'b0, "stall");
  endtask

  task automatic test_refill();
    reset_dut();
    do_refill(1, 20);
    check_stocks("refill_sat");
    do_refill(0, 3);
    check_stocks("refill_none");
    run_txn(2, 0, 1'b1, 1'b0, "refill_same");
  endtask

  task automatic test_clear_mid_eject();
    reset_dut();
    @(negedge clock); start = 1'b1; change = 3'd4;
    @(negedge clock); start = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (eject_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_pre valid: got %b want 1", eject_valid);
    end
    #2 clear = 1'b1;
    #1;
    n_cmp++;
    if ({eject_valid, busy, remaining} !== {1'b0, 1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL clr_async: got valid=%b busy=%b rem=%0d want 0 0 0", eject_valid, busy, remaining);
    end
    check_stocks("clr_async");
    @(negedge clock); clear = 1'b0;
  endtask

  task automatic test_back_to_back_busy_start();
    reset_dut();
    run_txn(4, 2, 1'b0, 1'b1, "busy_start");
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) do_refill($urandom_range(0, 3), $urandom_range(1, 4));
      run_txn($urandom_range(0, 7), 3, ($urandom_range(0, 4) == 0), 1'b0, "rand");
    end
    check_stocks("rand_end");
  endtask

`ifdef CHANGE_TIMEOUT_EN
  task automatic test_timeout();
    reset_dut();
    @(negedge clock); start = 1'b1; change = 3'd2;
    @(negedge clock); start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      n_cmp++;
      if ({eject_valid, eject_coin} !== {1'b1, 2'd2}) begin
        n_fail++;
        $display("FAIL tmo_wait %0d: got valid=%b coin=%0d want 1 2", i, eject_valid, eject_coin);
      end
    end
    @(negedge clock);
    n_cmp++;
    if ({done, fault, eject_valid, remaining} !== {1'b1, 1'b1, 1'b0, 3'd2}) begin
      n_fail++;
      $display("FAIL tmo_fault: got done=%b fault=%b valid=%b rem=%0d want 1 1 0 2",
               done, fault, eject_valid, remaining);
    end
    check_stocks("tmo");
    @(negedge clock);
  endtask
`endif

  initial begin
    test_reset();
    test_greedy();
    test_short();
    test_stall();
    test_refill();
    test_clear_mid_eject();
    test_back_to_back_busy_start();
`ifdef CHANGE_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
